ofdm_tx_cp_inserter: RTL
========================

# ofdm_tx_cp_inserter

Transmit-side counterpart of the OFDM RX chain's cyclic-prefix removal. It accepts time-domain I/Q samples of one raw OFDM symbol from the upstream IFFT and buffers them in a ping-pong RAM. It then emits the full symbol, cyclic prefix first and then the raw samples, paced at one sample per strobe period. Its output drives the RX chain's `rx_data_i/q/valid` inputs in loopback benches.

## Interface
- `sample_bit_width_g`, 12, width of each I and Q sample (signed).
- `raw_symbol_length_g`, 64, samples per symbol without CP (power of two).
- `symbol_length_g`, 80, samples per symbol with CP; CP length = `symbol_length_g - raw_symbol_length_g` (16).
- `strobe_period_g`, 24, sys_clk cycles per output sample.
- `sys_clk`  in  1  system clock, all logic on rising edge.
- `sys_rstn`  in  1  reset, asynchronous, active-low.
- `sys_init`  in  1  synchronous re-init pulse; same effect as reset.
- `in_data_i`, `in_data_q`  in  `sample_bit_width_g`  raw symbol samples.
- `in_data_valid`  in  1  sample qualifier.
- `in_symbol_start`  in  1  marks the first sample of a raw symbol; sampled only with valid.
- `in_ready`  out  1  a write bank is free.
- `tx_data_i`, `tx_data_q`  out  `sample_bit_width_g`  output samples.
- `tx_data_valid`  out  1  one-cycle pulse per output sample.
- `tx_symbol_start`  out  1  high together with the first CP sample of each symbol.
- `overflow`  out  1  sticky; a valid sample arrived while `in_ready`=0.

## Operation
- Two banks of `raw_symbol_length_g` entries. Each bank has a full flag, and there is one write-bank pointer (`wr_bank`) and one read-bank pointer (`rd_bank`).
- **Write side:**
  - Valid with `in_ready`=1 writes to `wr_bank[widx]` and increments `widx`.
  - `in_symbol_start` with valid forces `widx`=0 before the write (resync). A partially filled bank is discarded.
  - The write at `widx`=raw-1 sets `full[wr_bank]`, clears `widx` and toggles `wr_bank`.
  - `in_ready` = `!full[wr_bank]`.
  - Valid with `in_ready`=0: the sample is dropped and `overflow` is set.
- **Strobe counter:** counts 0..`strobe_period_g`-1 and wraps. A tick occurs at count `strobe_period_g`-1.
- **Read state machine:**
  - IDLE: on a tick with `full[rd_bank]`, read sample `ridx` = raw-CP and go to CP.
  - CP: each tick reads `ridx`++. After reading raw-1, wrap to 0 and go to BODY.
  - BODY: each tick reads `ridx`++. Reading raw-1 clears `full[rd_bank]`, toggles `rd_bank` and goes to IDLE.
- A symbol ready at end of BODY starts on the next tick; there is no gap tick.
- Setting and clearing a full flag in the same cycle always target different banks, so both take effect.
- Reset or `sys_init` clears all flags, indices, both bank pointers, the strobe counter, all outputs and `overflow`. RAM contents are don't-care.

## Timing
- Reset values: all outputs 0 except `in_ready`=1.
- RAM read is synchronous.
  - Tick in cycle N presents the read address.
  - `tx_data_*`, `tx_data_valid` and `tx_symbol_start` are registered and valid in cycle N+1.
  - `tx_data_valid` is high for exactly one cycle.
  - `tx_data_i/q` hold their value until the next valid.
- Input-to-output latency: first sample out one cycle after the first tick following the bank-fill cycle. Worst case `strobe_period_g`+1 cycles.
- Emitting one symbol takes `symbol_length_g`×`strobe_period_g` cycles (1920).
- `sys_init` mid-symbol aborts output immediately; no further valid pulses.

## Configuration
- `OFDM_TX_UNDERRUN_ZERO_EN`
  - **Defined:** a tick in IDLE with no full bank emits a zero sample with `tx_data_valid`=1 and `tx_symbol_start`=0, giving a constant sample rate.
  - **Undefined:** such ticks emit nothing.

## Structure
- `ofdm_tx_pkg` holds:
  - the read-FSM state enum (IDLE, CP, BODY);
  - a `sample_t` struct {i, q};
  - the CP-length constant function.
- Sub-module `ofdm_tx_sample_ram`: simple dual-port RAM, 2×raw entries of 2×width bits, one write port, one synchronous read port. Address = {bank, index}.

## Test plan
- Feed one symbol with samples I=k, Q=-k for k=0..63 -> 80 valid pulses spaced 24 cycles apart. I sequence is 48..63 then 0..63. `tx_symbol_start` is high only on the first pulse.
- Feed three symbols back-to-back at full rate -> `in_ready` drops after the 128th sample and rises again once bank 0 is drained. Output is 240 contiguous pulses. `overflow`=0.
- Drive valid while `in_ready`=0 -> `overflow`=1 and that sample is absent from the output. `sys_init` clears `overflow`.
- Send 30 samples, then `in_symbol_start` with a new 64-sample symbol -> only the new symbol is emitted (80 samples, starting with I=48).
- Assert `sys_rstn`=0 during sample 40 of the CP/BODY sequence -> outputs go to 0 immediately. After release there are no pulses until a new full symbol arrives.
- With `OFDM_TX_UNDERRUN_ZERO_EN` and no input -> valid pulses every 24 cycles with I=Q=0. Without the macro -> no pulses over 1000 cycles.

Source files
------------

// File: rtl/ofdm_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_tx_pkg
// Brief    : Shared types and helpers for the OFDM TX cyclic-prefix inserter.
// Revision : 1.0 - initial release
// ============================================================================
package ofdm_tx_pkg;

   localparam int SAMPLE_BIT_WIDTH = 12;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_CP   = 2'd1,
      RD_BODY = 2'd2
   } rd_state_t;

   typedef struct packed {
      logic signed [SAMPLE_BIT_WIDTH-1:0] i;
      logic signed [SAMPLE_BIT_WIDTH-1:0] q;
   } sample_t;

   function automatic int cp_length(input int symbol_length, input int raw_symbol_length);
      return symbol_length - raw_symbol_length;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ofdm_tx_sample_ram.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_tx_sample_ram
// Brief    : Simple dual-port sample RAM, one write port, one registered read.
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_tx_sample_ram #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q;

   // Read data holds between reads so the output sample stays stable.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/ofdm_tx_cp_inserter.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_tx_cp_inserter
// Brief    : Ping-pong buffers raw OFDM symbols, emits CP + body at strobe rate.
//            Option macro OFDM_TX_UNDERRUN_ZERO_EN: zero samples on idle ticks.
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_tx_cp_inserter
   import ofdm_tx_pkg::*;
#(
   parameter int sample_bit_width_g  = SAMPLE_BIT_WIDTH,
   parameter int raw_symbol_length_g = 64,
   parameter int symbol_length_g     = 80,
   parameter int strobe_period_g     = 24
) (
   input  logic                          sys_clk,
   input  logic                          sys_rstn,
   input  logic                          sys_init,
   input  logic [sample_bit_width_g-1:0] in_data_i,
   input  logic [sample_bit_width_g-1:0] in_data_q,
   input  logic                          in_data_valid,
   input  logic                          in_symbol_start,
   output logic                          in_ready,
   output logic [sample_bit_width_g-1:0] tx_data_i,
   output logic [sample_bit_width_g-1:0] tx_data_q,
   output logic                          tx_data_valid,
   output logic                          tx_symbol_start,
   output logic                          overflow
);

   localparam int W      = sample_bit_width_g;
   localparam int IDX_W  = $clog2(raw_symbol_length_g);
   localparam int CNT_W  = (strobe_period_g > 1) ? $clog2(strobe_period_g) : 1;
   localparam int CP_LEN = cp_length(symbol_length_g, raw_symbol_length_g);
   localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(raw_symbol_length_g - 1);
   localparam logic [IDX_W-1:0] IDX_CP_FIRST = IDX_W'(raw_symbol_length_g - CP_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(strobe_period_g - 1);

   logic [IDX_W-1:0] widx_q, widx_d, ridx_q, ridx_d;
   logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [1:0]       full_q, full_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   rd_state_t        state_q, state_d;
   logic             tx_valid_q, tx_valid_d, tx_start_q, tx_start_d, tx_zero_q, tx_zero_d;

   logic             tick, ram_wr_en, ram_rd_en;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [2*W-1:0]   ram_rd_data;

   assign in_ready = ~full_q[wr_bank_q];

   always_comb begin
      widx_d     = widx_q;
      ridx_d     = ridx_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      full_d     = full_q;
      overflow_d = overflow_q;
      state_d    = state_q;
      tx_valid_d = 1'b0;
      tx_start_d = 1'b0;
      tx_zero_d  = tx_zero_q;
      ram_wr_en  = 1'b0;
      ram_rd_en  = 1'b0;
      rd_idx     = ridx_q;
      tick       = (cnt_q == CNT_LAST);
      cnt_d      = tick ? '0 : cnt_q + 1'b1;
      // A symbol start resynchronises the write index, dropping any partial fill.
      wr_idx     = in_symbol_start ? '0 : widx_q;

      if (in_data_valid) begin
         if (in_ready) begin
            ram_wr_en = 1'b1;
            if (wr_idx == IDX_LAST) begin
               full_d[wr_bank_q] = 1'b1;
               widx_d            = '0;
               wr_bank_d         = ~wr_bank_q;
            end else begin
               widx_d = wr_idx + 1'b1;
            end
         end else begin
            overflow_d = 1'b1;
         end
      end

      if (tick) begin
         case (state_q)
            RD_IDLE: begin
               if (full_q[rd_bank_q]) begin
                  ram_rd_en  = 1'b1;
                  rd_idx     = IDX_CP_FIRST;
                  tx_valid_d = 1'b1;
                  tx_start_d = 1'b1;
                  tx_zero_d  = 1'b0;
                  if (IDX_CP_FIRST == IDX_LAST) begin
                     ridx_d  = '0;
                     state_d = RD_BODY;
                  end else begin
                     ridx_d  = IDX_CP_FIRST + 1'b1;
                     state_d = RD_CP;
                  end
               end
`ifdef OFDM_TX_UNDERRUN_ZERO_EN
               else begin
                  tx_valid_d = 1'b1;
                  tx_zero_d  = 1'b1;
               end
`endif
            end
            RD_CP: begin
               ram_rd_en  = 1'b1;
               tx_valid_d = 1'b1;
               tx_zero_d  = 1'b0;
               if (ridx_q == IDX_LAST) begin
                  ridx_d  = '0;
                  state_d = RD_BODY;
               end else begin
                  ridx_d = ridx_q + 1'b1;
               end
            end
            RD_BODY: begin
               ram_rd_en  = 1'b1;
               tx_valid_d = 1'b1;
               tx_zero_d  = 1'b0;
               if (ridx_q == IDX_LAST) begin
                  full_d[rd_bank_q] = 1'b0;
                  rd_bank_d         = ~rd_bank_q;
                  ridx_d            = '0;
                  state_d           = RD_IDLE;
               end else begin
                  ridx_d = ridx_q + 1'b1;
               end
            end
            default: state_d = RD_IDLE;
         endcase
      end

      if (sys_init) begin
         widx_d     = '0;
         ridx_d     = '0;
         wr_bank_d  = 1'b0;
         rd_bank_d  = 1'b0;
         full_d     = '0;
         overflow_d = 1'b0;
         cnt_d      = '0;
         state_d    = RD_IDLE;
         tx_valid_d = 1'b0;
         tx_start_d = 1'b0;
         tx_zero_d  = 1'b1;
         ram_wr_en  = 1'b0;
         ram_rd_en  = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         widx_q     <= '0;
         ridx_q     <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         full_q     <= '0;
         overflow_q <= 1'b0;
         cnt_q      <= '0;
         state_q    <= RD_IDLE;
         tx_valid_q <= 1'b0;
         tx_start_q <= 1'b0;
         tx_zero_q  <= 1'b1;
      end else begin
         widx_q     <= widx_d;
         ridx_q     <= ridx_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         tx_valid_q <= tx_valid_d;
         tx_start_q <= tx_start_d;
         tx_zero_q  <= tx_zero_d;
      end
   end

   ofdm_tx_sample_ram #(
      .DATA_W (2 * W),
      .ADDR_W (IDX_W + 1)
   ) u_ram (
      .clk     (sys_clk),
      .wr_en   (ram_wr_en),
      .wr_addr ({wr_bank_q, wr_idx}),
      .wr_data ({in_data_i, in_data_q}),
      .rd_en   (ram_rd_en),
      .rd_addr ({rd_bank_q, rd_idx}),
      .rd_data (ram_rd_data)
   );

   // The RAM output register carries the sample; the zero flag masks it after reset/underrun.
   assign tx_data_i       = tx_zero_q ? '0 : ram_rd_data[2*W-1 -: W];
   assign tx_data_q       = tx_zero_q ? '0 : ram_rd_data[W-1:0];
   assign tx_data_valid   = tx_valid_q;
   assign tx_symbol_start = tx_start_q;
   assign overflow        = overflow_q;

endmodule
`default_nettype wire
